// File: rtl/led_if.sv
// Switch, display and debug signals of the LED counter block.
// The debug pair exposes the BCD count and the scan state for checkers.
interface led_if;
    logic [5:0]  switch;
    logic [7:0]  seven_segment;
    logic [2:0]  enable;
    logic [11:0] value_dbg;
    logic [1:0]  index_dbg;

    modport master (
        output switch,
        input  seven_segment,
        input  enable,
        input  value_dbg,
        input  index_dbg
    );

    modport slave (
        input  switch,
        output seven_segment,
        output enable,
        output value_dbg,
        output index_dbg
    );
endinterface

// File: rtl/led.sv
// Three-digit BCD up/down/clear counter driven by debounced push switches,
// shown on a multiplexed active-low seven-segment display.
module led #(
    parameter int SCAN_DIV = 1024,
    parameter int DEBOUNCE = 16
) (
    input logic  clk,
    input logic  rst_n,
    led_if.slave io
);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_t;

    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  press;
    logic [11:0] value;
    logic [15:0] scan_cnt;
    digit_t      state;
    digit_t      state_next;
    logic [3:0]  digit_next;
    logic [2:0]  enable_next;
    logic [2:0]  enable_q;
    logic [7:0]  seg_q;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] != 4'd9) begin
            r[3:0] = r[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd9) begin
                r[7:4] = r[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] != 4'd0) begin
            r[3:0] = r[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) begin
                r[7:4] = r[7:4] - 4'd1;
            end else begin
                r[7:4]  = 4'd9;
                r[11:8] = (r[11:8] == 4'd0) ? 4'd9 : r[11:8] - 4'd1;
            end
        end
        return r;
    endfunction

    // Only the three function switches are synchronized; [5:3] have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= io.switch[2:0];
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic        level;
        logic [15:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level <= 1'b1;
                cnt   <= '0;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= sync2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end

        // High for the single cycle in which the accepted level falls 1 -> 0.
        assign press[i] = level & ~sync2[i] & (cnt == DB_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (press[2]) begin
            value <= '0;
        end else if (press[0] && !press[1]) begin
            value <= bcd_inc(value);
        end else if (press[1] && !press[0]) begin
            value <= bcd_dec(value);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            state    <= DIG_UNITS;
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 16'd1;
            state    <= state_next;
        end
    end

    // Outputs are registered from the next digit so Enable and segments move together.
    always_comb begin
        state_next  = state;
        enable_next = 3'b110;
        digit_next  = value[3:0];
        if (scan_cnt == SCAN_LAST) begin
            case (state)
                DIG_UNITS: state_next = DIG_TENS;
                DIG_TENS:  state_next = DIG_HUNDREDS;
                default:   state_next = DIG_UNITS;
            endcase
        end
        case (state_next)
            DIG_UNITS: begin
                enable_next = 3'b110;
                digit_next  = value[3:0];
            end
            DIG_TENS: begin
                enable_next = 3'b101;
                digit_next  = value[7:4];
            end
            default: begin
                enable_next = 3'b011;
                digit_next  = value[11:8];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 3'b110;
            seg_q    <= 8'h03;
        end else begin
            enable_q <= enable_next;
            seg_q    <= seg_encode(digit_next);
        end
    end

    assign io.enable        = enable_q;
    assign io.seven_segment = seg_q;
    assign io.value_dbg     = value;
    assign io.index_dbg     = state;
endmodule

// File: tb/tb_led.sv
// Randomized self-checking bench for the LED counter against an integer model.
module tb_led;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_if io();

    led #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int n_checks = 0;
    int n_fail = 0;
    int model_value = 0;
    int edge_cnt = 0;
    logic [11:0] exp_q[$];
    logic [7:0] seg_tab[10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    // Edges since the last reset release; the scan position follows from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dut_value();
        return int'(io.value_dbg[11:8]) * 100 + int'(io.value_dbg[7:4]) * 10 + int'(io.value_dbg[3:0]);
    endfunction

    function automatic int digit_of(input int v, input int idx);
        if (idx == 0) return v % 10;
        if (idx == 1) return (v / 10) % 10;
        return v / 100;
    endfunction

    task automatic apply_model(input logic [2:0] m);
        if (m[2])              model_value = 0;
        else if (m[0] && !m[1]) model_value = (model_value + 1) % 1000;
        else if (m[1] && !m[0]) model_value = (model_value + 999) % 1000;
    endtask

    task automatic check_value(input string tag);
        logic [11:0] e;
        exp_q.push_back(12'(model_value));
        e = exp_q.pop_front();
        check(tag, 32'(dut_value()), 32'(e));
    endtask

    task automatic scan_check(input int n);
        int idx;
        logic [2:0] exp_en;
        check_value("value");
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            idx = (edge_cnt / SCAN_DIV) % 3;
            exp_en = ~(3'b001 << idx);
            check("enable", 32'(io.enable), 32'(exp_en));
            check("index", 32'(io.index_dbg), 32'(idx));
            check("segment", 32'(io.seven_segment), 32'(seg_tab[digit_of(model_value, idx)]));
        end
    endtask

    task automatic press(input logic [2:0] m, input int hold, input bit do_scan);
        io.switch[2:0] = ~m;
        for (int k = 0; k < hold; k++) begin
            io.switch[5:3] = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        io.switch = {3'($urandom_range(0, 7)), 3'b111};
        repeat (DEBOUNCE + 6) @(negedge clk);
        apply_model(m);
        if (do_scan) scan_check(3 * SCAN_DIV);
    endtask

    initial begin
        #1ms;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int waited;
        io.switch = 6'h3F;
        rst_n = 1'b0;
        #12;
        check("rst_enable", 32'(io.enable), 32'h6);
        check("rst_segment", 32'(io.seven_segment), 32'h03);
        check("rst_value", 32'(dut_value()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_value = 0;
        scan_check(4 * SCAN_DIV);

        // Alternating increment / decrement holds of 50 cycles each.
        for (int r = 0; r < 2; r++) begin
            io.switch = 6'b111110;
            repeat (30) @(negedge clk);
            apply_model(3'b001);
            scan_check(3 * SCAN_DIV);
            repeat (8) @(negedge clk);
            io.switch = 6'b111101;
            repeat (30) @(negedge clk);
            apply_model(3'b010);
            scan_check(3 * SCAN_DIV);
            repeat (8) @(negedge clk);
        end
        io.switch = 6'h3F;
        repeat (DEBOUNCE + 6) @(negedge clk);

        // Wrap boundaries, then a glitch shorter than the debounce window.
        press(3'b100, DEBOUNCE + 6, 1'b1);
        press(3'b010, DEBOUNCE + 6, 1'b1);
        press(3'b001, DEBOUNCE + 6, 1'b1);
        io.switch[0] = 1'b0;
        repeat (3) @(negedge clk);
        io.switch[0] = 1'b1;
        repeat (20) @(negedge clk);
        scan_check(3 * SCAN_DIV);

        // Press latency from a clean switch edge, bounded.
        @(negedge clk);
        io.switch[0] = 1'b0;
        lat = 0;
        while (dut_value() == model_value && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("press_latency", 32'(lat >= DEBOUNCE + 2 && lat <= DEBOUNCE + 4), 32'd1);
        io.switch[0] = 1'b1;
        repeat (DEBOUNCE + 6) @(negedge clk);
        apply_model(3'b001);
        scan_check(3 * SCAN_DIV);

        // Simultaneous events from 005.
        press(3'b100, DEBOUNCE + 6, 1'b0);
        for (int k = 0; k < 5; k++) press(3'b001, DEBOUNCE + 6, 1'b0);
        scan_check(3 * SCAN_DIV);
        press(3'b011, DEBOUNCE + 6, 1'b1);
        press(3'b101, DEBOUNCE + 6, 1'b1);

        for (int k = 0; k < 25; k++) begin
            press(3'($urandom_range(0, 7)), $urandom_range(DEBOUNCE + 6, DEBOUNCE + 20), 1'b1);
        end

        // Reach 123, then reset with Switch[0] held low through release.
        press(3'b100, DEBOUNCE + 6, 1'b0);
        for (int k = 0; k < 123; k++) press(3'b001, DEBOUNCE + 6, 1'b0);
        scan_check(3 * SCAN_DIV);
        waited = 0;
        while (io.enable == 3'b110 && waited < 3 * SCAN_DIV) begin
            @(negedge clk);
            waited++;
        end
        check("enable_not_units", 32'(io.enable != 3'b110), 32'd1);
        io.switch[0] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_enable", 32'(io.enable), 32'h6);
        check("midrst_segment", 32'(io.seven_segment), 32'h03);
        model_value = 0;
        check_value("midrst_value");
        repeat (3) @(negedge clk);
        check_value("held_rst_value");
        rst_n = 1'b1;
        repeat (DEBOUNCE + 4) @(negedge clk);
        apply_model(3'b001);
        check_value("held_press_value");
        repeat (20) @(negedge clk);
        check_value("held_single_press");
        io.switch[0] = 1'b1;
        repeat (DEBOUNCE + 6) @(negedge clk);
        scan_check(3 * SCAN_DIV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/led.md
LED -- requirements
Module: led

Interface
REQ-001 Parameter SCAN_DIV, default 1024: clock cycles each digit stays enabled; legal 2..65535.
REQ-002 Parameter DEBOUNCE, default 16: consecutive stable synchronized cycles needed to accept a switch level; legal 1..65535.
REQ-003 Clk  input  1  system clock; all state on rising edge.
REQ-004 Rst  input  1  reset; one clock, asynchronous assert, active-low (0 = reset).
REQ-005 Switch  input  6  push switches, active-low (0 = pressed), asynchronous to Clk.
REQ-006 SevenSegment  output  8  segment drive, active-low; [7]=a,[6]=b,[5]=c,[4]=d,[3]=e,[2]=f,[1]=g,[0]=dp.
REQ-007 Enable  output  3  digit enables, active-low one-hot; [0]=units, [1]=tens, [2]=hundreds.

Function
REQ-008 Each Switch bit SHALL pass a 2-flop synchronizer, then a debouncer that updates the accepted level only after DEBOUNCE consecutive equal synchronized samples.
REQ-009 A press SHALL be a 1->0 transition of an accepted level; one press event, one cycle wide.
REQ-010 Value SHALL be a 3-digit BCD counter, range 000..999.
REQ-011 Switch[0] press SHALL increment value; 999 wraps to 000.
REQ-012 Switch[1] press SHALL decrement value; 000 wraps to 999.
REQ-013 Switch[2] press SHALL clear value to 000.
REQ-014 Same-cycle events: clear has priority over all; increment and decrement together SHALL leave value unchanged.
REQ-015 Switch[5:3] SHALL be ignored.
REQ-016 Value SHALL update on the Clk edge after the press event. A switch change stable from cycle 0 SHALL show its press event by cycle 2+DEBOUNCE+1.
REQ-017 A scan counter SHALL advance digit index 0->1->2->0 every SCAN_DIV cycles.
REQ-018 Enable SHALL be registered and equal ~(1<<index): 110, 101, 011.
REQ-019 SevenSegment SHALL be registered, change on the same edge as Enable, and show the digit selected by the current index.
REQ-020 Leading zeros SHALL be displayed (no blanking); dp SHALL always be off (bit0=1).
REQ-021 Digit encodings (hex, active-low): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09.
REQ-022 A value change SHALL appear on the next edge at which its digit is driven; scan timing SHALL NOT be disturbed by value changes.
REQ-023 Exactly one Enable bit SHALL be low at all times outside reset and after reset.

Reset
REQ-024 While Rst=0: value=000, index=0, scan and debounce counters=0, synchronizers and accepted levels=1 (released), Enable=3'b110, SevenSegment=8'h03.
REQ-025 Reset SHALL take effect without a clock edge. The first scan period after release SHALL be exactly SCAN_DIV cycles.
REQ-026 A switch held low through reset release SHALL be accepted after DEBOUNCE stable cycles and count as one press.

Verification (SCAN_DIV=4, DEBOUNCE=4)
REQ-027 Rst=0 mid-cycle -> Enable=110, SevenSegment=03 immediately. After release, Enable sequence 110,101,011,110 with 4 cycles each; SevenSegment=03 throughout.
REQ-028 Switch alternating 111110 / 111101, each held 50 cycles -> value 001 after the first hold, 000 after the second, repeating; units digit alternates 9F / 03.
REQ-029 From 000, one Switch[1] press -> 999; all three digits show 09 during their scan slots.
REQ-030 From 999, one Switch[0] press -> 000. Then a 3-cycle low glitch on Switch[0] -> value stays 000.
REQ-031 Switch[0] and Switch[1] pressed in the same cycle from 005 -> value stays 005. Switch[2] with Switch[0] -> 000.
REQ-032 Rst pulsed low while value=123 and Switch[0] held low -> value 000 during reset, then 001 after DEBOUNCE+2 cycles post-release.
